// File: rtl/xbar_slave_port_if.sv
// xbar_slave_port_if: crossbar-side and slave-side signals of one crossbar slave port.
interface xbar_slave_port_if #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MASTERS_COUNT = 4
);
    localparam int MID_W = MASTERS_COUNT > 1 ? $clog2(MASTERS_COUNT) : 1;
    logic              x_req;
    logic [ADDR_W-1:0] x_addr;
    logic              x_cmd;
    logic [DATA_W-1:0] x_wdata;
    logic [MID_W-1:0]  x_mid;
    logic              x_ack;
    logic              x_rvalid;
    logic [DATA_W-1:0] x_rdata;
    logic [MID_W-1:0]  x_rmid;
    logic              x_err;
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic              s_cmd;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;
    logic [7:0]        err_cnt;
    modport slave (
        input  x_req, x_addr, x_cmd, x_wdata, x_mid, s_ack, s_rdata,
        output x_ack, x_rvalid, x_rdata, x_rmid, x_err, s_req, s_addr, s_cmd, s_wdata, err_cnt
    );
    modport master (
        output x_req, x_addr, x_cmd, x_wdata, x_mid, s_ack, s_rdata,
        input  x_ack, x_rvalid, x_rdata, x_rmid, x_err, s_req, s_addr, s_cmd, s_wdata, err_cnt
    );
endinterface

// File: rtl/xbar_slave_port.sv
// xbar_slave_port: forwards one crossbar request at a time to a slave, with timeout and error count.
module xbar_slave_port #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MASTERS_COUNT = 4,
    parameter int TIMEOUT       = 255
) (
    input logic clk,
    input logic reset,
    xbar_slave_port_if.slave bus
);
    localparam int MID_W = MASTERS_COUNT > 1 ? $clog2(MASTERS_COUNT) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx, err_cnt, err_cnt_nx;
    logic              ack, ack_nx, rvalid, rvalid_nx, err, err_nx;
    logic              s_req, s_req_nx, s_cmd, s_cmd_nx;
    logic [ADDR_W-1:0] s_addr, s_addr_nx;
    logic [DATA_W-1:0] s_wdata, s_wdata_nx, rdata, rdata_nx;
    logic [MID_W-1:0]  rmid, rmid_nx;
    logic              timeout;
    assign timeout = cnt == 8'(TIMEOUT - 1);
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        err_cnt_nx = err_cnt;
        ack_nx     = 1'b0;
        rvalid_nx  = 1'b0;
        err_nx     = 1'b0;
        s_req_nx   = s_req;
        s_cmd_nx   = s_cmd;
        s_addr_nx  = s_addr;
        s_wdata_nx = s_wdata;
        rdata_nx   = rdata;
        rmid_nx    = rmid;
        case (state)
            IDLE: if (bus.x_req) begin
                state_nx   = WAIT;
                cnt_nx     = '0;
                ack_nx     = 1'b1;
                s_req_nx   = 1'b1;
                s_cmd_nx   = bus.x_cmd;
                s_addr_nx  = bus.x_addr;
                s_wdata_nx = bus.x_wdata;
                rmid_nx    = bus.x_mid;
            end
            WAIT: begin
                // a completion on the timeout edge still counts as a normal response
                if (bus.s_ack || timeout) begin
                    state_nx   = RESP;
                    s_req_nx   = 1'b0;
                    rvalid_nx  = 1'b1;
                    err_nx     = !bus.s_ack;
                    rdata_nx   = (bus.s_ack && !s_cmd) ? bus.s_rdata : '0;
                    err_cnt_nx = (!bus.s_ack && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            err_cnt <= '0;
            ack     <= 1'b0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            s_req   <= 1'b0;
            s_cmd   <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            rdata   <= '0;
            rmid    <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            err_cnt <= err_cnt_nx;
            ack     <= ack_nx;
            rvalid  <= rvalid_nx;
            err     <= err_nx;
            s_req   <= s_req_nx;
            s_cmd   <= s_cmd_nx;
            s_addr  <= s_addr_nx;
            s_wdata <= s_wdata_nx;
            rdata   <= rdata_nx;
            rmid    <= rmid_nx;
        end
    end
    assign bus.x_ack    = ack;
    assign bus.x_rvalid = rvalid;
    assign bus.x_err    = err;
    assign bus.x_rdata  = rdata;
    assign bus.x_rmid   = rmid;
    assign bus.s_req    = s_req;
    assign bus.s_cmd    = s_cmd;
    assign bus.s_addr   = s_addr;
    assign bus.s_wdata  = s_wdata;
    assign bus.err_cnt  = err_cnt;
endmodule
